wb_commit_unit: RTL and testbench
=================================

# wb_commit_unit

Writeback-side consumer of the EX/WB pipeline register. Each cycle it takes the instruction in the WB stage, selects and commits the register-file write, maintains the architectural Z/N flags, resolves branches/jumps into a registered PC redirect, and squashes the wrong-path instructions still in flight behind a taken transfer. It sits between the EX/WB buffer and the register file write port and PC mux.

## Interface
- SQUASH_DEPTH, 3: number of WB-stage instructions discarded after a taken transfer (1..7)
- RF_AW, 6: register index width

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- valid_wb  in  1  WB-stage instruction present
- writeBackControl_wb  in  2  write source: 00 aluResult, 01 readData, 10 pc_plus_y, 11 none
- regWrt_wb  in  1  instruction writes rd
- rd_wb  in  RF_AW  destination register index
- branchZero_wb, branchNeg_wb, jump_wb, jumpMem_wb  in  1 each  transfer type
- pc_plus_y_wb, xrs_wb, readData_wb, aluResult_wb  in  32 each  operands
- z_wb, n_wb  in  1 each  ALU flags of this instruction
- rf_we  out  1  register-file write enable
- rf_waddr  out  RF_AW  write index
- rf_wdata  out  32  write data
- redirect  out  1  one-cycle PC redirect pulse
- redirect_pc  out  32  redirect target
- flush  out  1  squash in progress
- flag_z, flag_n  out  1 each  architectural flags

## Operation
- Accept: instruction accepted when valid_wb=1 and state=RUN; ignored otherwise.
- Write: rf_we=1 iff accepted, regWrt_wb=1, writeBackControl_wb≠11, and no transfer bit set; rf_wdata from the selected source; rf_waddr=rd_wb.
- Flags: on an accepted write with writeBackControl_wb=00, flag_z/flag_n load z_wb/n_wb. Other instructions leave flags unchanged.
- Transfer priority: jumpMem (target readData_wb) > jump (target xrs_wb) > branchZero (taken iff flag_z) > branchNeg (taken iff flag_n); branches test the flags held before this instruction.
- Taken transfer: redirect=1, redirect_pc=target, state→SQUASH, counter=SQUASH_DEPTH. Not-taken branch: no effect.
- FSM: RUN, SQUASH. In SQUASH, counter decrements every cycle valid_wb=1 (dropped instruction); at counter=1 with valid_wb=1 return to RUN next cycle. Cycles with valid_wb=0 do not decrement.
- flush=1 exactly while state=SQUASH.
- No writes, flag updates, or redirects from squashed instructions.

## Timing
- All outputs registered; result of instruction at edge N visible after edge N (latency 1).
- redirect high for exactly one cycle; redirect_pc holds last target until next redirect.
- flush rises in the same cycle as redirect.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, redirect=0, redirect_pc=0, flush=0, flag_z=0, flag_n=0, state=RUN, counter=0.
- Reset mid-squash: immediately RUN, flush=0, pending drops abandoned.
- Back-to-back writes to the same rd: each committed in order, one per cycle.
- Flag-setting instruction followed directly by a branch: branch sees the new flags (flags update at the edge the ALU op is accepted).

## Configuration
- WB_PERF_CNT_EN defined: adds outputs retired_cnt[31:0] (accepted instructions) and squashed_cnt[31:0] (dropped valid instructions), both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package scu_pkg: writeBackControl encodings (WB_ALU, WB_MEM, WB_PCY, WB_NONE), commit FSM state enum, RF_AW default.
- One sub-module: wb_squash_ctr (load, decrement-on-valid, done output), owning the RUN/SQUASH state.

## Test plan
- ALU write: valid, wbctl=00, regWrt, rd=5, aluResult=0x1234, z=0,n=1 -> next cycle rf_we=1, waddr=5, wdata=0x1234, flag_n=1.
- SVPC: wbctl=10, pc_plus_y=0x40 to rd=7 -> wdata=0x40; wbctl=11 with regWrt -> rf_we=0.
- brz after ALU op with z=1, xrs=0x80 -> redirect pulse, redirect_pc=0x80, flush=1; next 3 valid instructions (incl. writes) produce rf_we=0; flush drops after third.
- Squash with bubbles: taken jump then valid pattern 1,0,0,1,1 -> flush stays high across bubbles, releases after third valid.
- Priority: jumpMem and jump both set, readData=0x100, xrs=0x200 -> redirect_pc=0x100; brn with flag_n=0 -> no redirect.
- Reset asserted mid-squash -> all outputs to reset values same cycle; next valid ALU write commits normally; with WB_PERF_CNT_EN, counters read 0 then 1.

Source files
------------

// File: rtl/scu_pkg.sv
// Shared definitions for the writeback commit unit.
// Contents: writeBackControl source encodings, commit FSM state type,
// default register-index width.
package scu_pkg;

  localparam int unsigned RF_AW_DEFAULT = 6;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PCY  = 2'b10,
    WB_NONE = 2'b11
  } wb_ctl_e;

  typedef enum logic {
    StRun,
    StSquash
  } commit_state_e;

endpackage

// File: rtl/wb_commit_unit_if.sv
// EX/WB-to-commit bundle: WB-stage instruction fields toward the commit unit,
// register-file write, PC redirect, flush and architectural flags back out.
// Modports: master drives the WB stage and observes results; slave is the
// commit unit.
interface wb_commit_unit_if #(
  parameter int unsigned RF_AW = scu_pkg::RF_AW_DEFAULT
);
  logic              valid_wb;
  logic [1:0]        writeBackControl_wb;
  logic              regWrt_wb;
  logic [RF_AW-1:0]  rd_wb;
  logic              branchZero_wb;
  logic              branchNeg_wb;
  logic              jump_wb;
  logic              jumpMem_wb;
  logic [31:0]       pc_plus_y_wb;
  logic [31:0]       xrs_wb;
  logic [31:0]       readData_wb;
  logic [31:0]       aluResult_wb;
  logic              z_wb;
  logic              n_wb;

  logic              rf_we;
  logic [RF_AW-1:0]  rf_waddr;
  logic [31:0]       rf_wdata;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              flush;
  logic              flag_z;
  logic              flag_n;

  modport master (
    output valid_wb, writeBackControl_wb, regWrt_wb, rd_wb,
    output branchZero_wb, branchNeg_wb, jump_wb, jumpMem_wb,
    output pc_plus_y_wb, xrs_wb, readData_wb, aluResult_wb, z_wb, n_wb,
    input  rf_we, rf_waddr, rf_wdata, redirect, redirect_pc, flush, flag_z, flag_n
  );

  modport slave (
    input  valid_wb, writeBackControl_wb, regWrt_wb, rd_wb,
    input  branchZero_wb, branchNeg_wb, jump_wb, jumpMem_wb,
    input  pc_plus_y_wb, xrs_wb, readData_wb, aluResult_wb, z_wb, n_wb,
    output rf_we, rf_waddr, rf_wdata, redirect, redirect_pc, flush, flag_z, flag_n
  );
endinterface

// File: rtl/wb_squash_ctr.sv
// Owns the RUN/SQUASH commit state and the wrong-path drop counter.
// Ports: clock, reset (async, active-high); load - taken transfer accepted;
// valid - WB-stage instruction present; done - high in RUN (no squash pending).
module wb_squash_ctr
  import scu_pkg::*;
#(
  parameter int unsigned SQUASH_DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic valid,
  output logic done
);

  commit_state_e state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (load) begin
          state_d = StSquash;
          cnt_d   = 3'(SQUASH_DEPTH);
        end
      end
      StSquash: begin
        // Bubbles are not wrong-path instructions, so only valid slots count.
        if (valid) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign done = (state_q == StRun);

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit unit: commits the WB-stage register write, keeps the Z/N
// flags, resolves jumps/branches into a registered one-cycle redirect and
// squashes SQUASH_DEPTH wrong-path instructions after a taken transfer.
// Ports: clock, reset (async, active-high); wb - wb_commit_unit_if slave.
// Optional: WB_PERF_CNT_EN adds retired_cnt / squashed_cnt outputs.
module wb_commit_unit
  import scu_pkg::*;
#(
  parameter int unsigned SQUASH_DEPTH = 3,
  parameter int unsigned RF_AW        = RF_AW_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  wb_commit_unit_if.slave  wb
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]      retired_cnt,
  output logic [31:0]      squashed_cnt
`endif
);

  logic             running;
  logic             accept;
  logic             any_xfer;
  logic             taken;
  logic [31:0]      target;
  logic             wr_en;
  logic [31:0]      wr_data;
  wb_ctl_e          ctl;

  logic             rf_we_q;
  logic [RF_AW-1:0] rf_waddr_q;
  logic [31:0]      rf_wdata_q;
  logic             redirect_q;
  logic [31:0]      redirect_pc_q;
  logic             flag_z_q, flag_n_q;

  assign ctl      = wb_ctl_e'(wb.writeBackControl_wb);
  assign accept   = wb.valid_wb & running;
  assign any_xfer = wb.jumpMem_wb | wb.jump_wb | wb.branchZero_wb | wb.branchNeg_wb;
  assign wr_en    = accept & wb.regWrt_wb & (ctl != WB_NONE) & ~any_xfer;

  // Branches test the flags as held before this instruction.
  always_comb begin
    taken  = 1'b0;
    target = wb.xrs_wb;
    if (wb.jumpMem_wb) begin
      taken  = 1'b1;
      target = wb.readData_wb;
    end else if (wb.jump_wb) begin
      taken  = 1'b1;
    end else if (wb.branchZero_wb) begin
      taken  = flag_z_q;
    end else if (wb.branchNeg_wb) begin
      taken  = flag_n_q;
    end
    taken = taken & accept;
  end

  always_comb begin
    wr_data = '0;
    unique case (ctl)
      WB_ALU:  wr_data = wb.aluResult_wb;
      WB_MEM:  wr_data = wb.readData_wb;
      WB_PCY:  wr_data = wb.pc_plus_y_wb;
      default: wr_data = '0;
    endcase
  end

  wb_squash_ctr #(
    .SQUASH_DEPTH (SQUASH_DEPTH)
  ) u_squash_ctr (
    .clock (clock),
    .reset (reset),
    .load  (taken),
    .valid (wb.valid_wb),
    .done  (running)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flag_z_q      <= 1'b0;
      flag_n_q      <= 1'b0;
    end else begin
      rf_we_q    <= wr_en;
      redirect_q <= taken;
      if (wr_en) begin
        rf_waddr_q <= wb.rd_wb;
        rf_wdata_q <= wr_data;
      end
      if (wr_en && ctl == WB_ALU) begin
        flag_z_q <= wb.z_wb;
        flag_n_q <= wb.n_wb;
      end
      if (taken) redirect_pc_q <= target;
    end
  end

  assign wb.rf_we       = rf_we_q;
  assign wb.rf_waddr    = rf_waddr_q;
  assign wb.rf_wdata    = rf_wdata_q;
  assign wb.redirect    = redirect_q;
  assign wb.redirect_pc = redirect_pc_q;
  assign wb.flush       = ~running;
  assign wb.flag_z      = flag_z_q;
  assign wb.flag_n      = flag_n_q;

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_cnt  <= '0;
      squashed_cnt <= '0;
    end else begin
      if (accept) retired_cnt <= retired_cnt + 32'd1;
      if (wb.valid_wb && !running) squashed_cnt <= squashed_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed self-checking bench for wb_commit_unit (default SQUASH_DEPTH=3).
module tb_wb_commit_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  wb_commit_unit_if #(.RF_AW(6)) bus ();

`ifdef WB_PERF_CNT_EN
  logic [31:0] retired_cnt, squashed_cnt;
`endif

  wb_commit_unit #(
    .SQUASH_DEPTH (3),
    .RF_AW        (6)
  ) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus.slave)
`ifdef WB_PERF_CNT_EN
    ,
    .retired_cnt  (retired_cnt),
    .squashed_cnt (squashed_cnt)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // xfer = {jumpMem, jump, branchZero, branchNeg}
  task automatic drive(input logic v, input logic [1:0] ctl, input logic rw,
                       input logic [5:0] rd, input logic [3:0] xfer,
                       input logic [31:0] alu, input logic [31:0] rdat,
                       input logic [31:0] pcy, input logic [31:0] xrs,
                       input logic z, input logic n);
    bus.valid_wb            = v;
    bus.writeBackControl_wb = ctl;
    bus.regWrt_wb           = rw;
    bus.rd_wb               = rd;
    bus.jumpMem_wb          = xfer[3];
    bus.jump_wb             = xfer[2];
    bus.branchZero_wb       = xfer[1];
    bus.branchNeg_wb        = xfer[0];
    bus.aluResult_wb        = alu;
    bus.readData_wb         = rdat;
    bus.pc_plus_y_wb        = pcy;
    bus.xrs_wb              = xrs;
    bus.z_wb                = z;
    bus.n_wb                = n;
  endtask

  task automatic idle();
    drive(1'b0, 2'b11, 1'b0, 6'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic alu_wr(input logic [5:0] rd, input logic [31:0] d, input logic z,
                        input logic n);
    drive(1'b1, 2'b00, 1'b1, rd, 4'b0000, d, 32'h0, 32'h0, 32'h0, z, n);
  endtask

  task automatic test_reset();
    idle();
    #3;
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", bus.rf_we); end
    total++; if (bus.rf_waddr !== 6'd0) begin bad++; $display("FAIL reset_waddr got=%0d want=0", bus.rf_waddr); end
    total++; if (bus.rf_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", bus.rf_wdata); end
    total++; if (bus.redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%0b want=0", bus.redirect); end
    total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_rpc got=%h want=0", bus.redirect_pc); end
    total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b want=0", bus.flush); end
    total++; if ({bus.flag_z, bus.flag_n} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {bus.flag_z, bus.flag_n}); end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu_write();
    alu_wr(6'd5, 32'h1234, 1'b0, 1'b1);
    step();
    total++; if (bus.rf_we !== 1'b1) begin bad++; $display("FAIL alu_we got=%0b want=1", bus.rf_we); end
    total++; if (bus.rf_waddr !== 6'd5) begin bad++; $display("FAIL alu_waddr got=%0d want=5", bus.rf_waddr); end
    total++; if (bus.rf_wdata !== 32'h1234) begin bad++; $display("FAIL alu_wdata got=%h want=1234", bus.rf_wdata); end
    total++; if ({bus.flag_z, bus.flag_n} !== 2'b01) begin bad++; $display("FAIL alu_flags got=%b want=01", {bus.flag_z, bus.flag_n}); end
    idle();
    step();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL alu_we_drop got=%0b want=0", bus.rf_we); end
  endtask

  task automatic test_sources();
    drive(1'b1, 2'b10, 1'b1, 6'd7, 4'b0000, 32'h0, 32'h0, 32'h40, 32'h0, 1'b1, 1'b0);
    step();
    total++; if (bus.rf_we !== 1'b1) begin bad++; $display("FAIL svpc_we got=%0b want=1", bus.rf_we); end
    total++; if (bus.rf_waddr !== 6'd7) begin bad++; $display("FAIL svpc_waddr got=%0d want=7", bus.rf_waddr); end
    total++; if (bus.rf_wdata !== 32'h40) begin bad++; $display("FAIL svpc_wdata got=%h want=40", bus.rf_wdata); end
    total++; if ({bus.flag_z, bus.flag_n} !== 2'b01) begin bad++; $display("FAIL svpc_flags got=%b want=01", {bus.flag_z, bus.flag_n}); end
    drive(1'b1, 2'b11, 1'b1, 6'd9, 4'b0000, 32'h99, 32'h99, 32'h99, 32'h0, 1'b0, 1'b0);
    step();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL none_we got=%0b want=0", bus.rf_we); end
    drive(1'b1, 2'b01, 1'b1, 6'd3, 4'b0000, 32'h0, 32'hdeadbeef, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    total++; if (bus.rf_wdata !== 32'hdeadbeef) begin bad++; $display("FAIL mem_wdata got=%h want=deadbeef", bus.rf_wdata); end
    total++; if (bus.rf_waddr !== 6'd3) begin bad++; $display("FAIL mem_waddr got=%0d want=3", bus.rf_waddr); end
    drive(1'b1, 2'b00, 1'b0, 6'd8, 4'b0000, 32'h5, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL noregwrt_we got=%0b want=0", bus.rf_we); end
    total++; if ({bus.flag_z, bus.flag_n} !== 2'b01) begin bad++; $display("FAIL noregwrt_flags got=%b want=01", {bus.flag_z, bus.flag_n}); end
    idle();
  endtask

  task automatic test_back_to_back();
    alu_wr(6'd4, 32'h11, 1'b0, 1'b0);
    step();
    total++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 6'd4, 32'h11}) begin bad++; $display("FAIL b2b_first got=%b/%0d/%h want=1/4/11", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    alu_wr(6'd4, 32'h22, 1'b1, 1'b0);
    step();
    total++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 6'd4, 32'h22}) begin bad++; $display("FAIL b2b_second got=%b/%0d/%h want=1/4/22", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    total++; if ({bus.flag_z, bus.flag_n} !== 2'b10) begin bad++; $display("FAIL b2b_flags got=%b want=10", {bus.flag_z, bus.flag_n}); end
    idle();
    step();
  endtask

  task automatic test_branch_squash();
    alu_wr(6'd1, 32'h0, 1'b1, 1'b0);
    step();
    // brz directly after the flag-setting op; regWrt set but transfer blocks the write
    drive(1'b1, 2'b00, 1'b1, 6'd2, 4'b0010, 32'h9, 32'h0, 32'h0, 32'h80, 1'b0, 1'b1);
    step();
    total++; if (bus.redirect !== 1'b1) begin bad++; $display("FAIL brz_redirect got=%0b want=1", bus.redirect); end
    total++; if (bus.redirect_pc !== 32'h80) begin bad++; $display("FAIL brz_rpc got=%h want=80", bus.redirect_pc); end
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL brz_flush got=%0b want=1", bus.flush); end
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL brz_we got=%0b want=0", bus.rf_we); end
    for (int i = 0; i < 3; i++) begin
      alu_wr(6'd10, 32'h55, 1'b0, 1'b1);
      step();
      total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL sq_we[%0d] got=%0b want=0", i, bus.rf_we); end
      total++; if (bus.redirect !== 1'b0) begin bad++; $display("FAIL sq_redirect[%0d] got=%0b want=0", i, bus.redirect); end
      total++; if (bus.flush !== (i < 2)) begin bad++; $display("FAIL sq_flush[%0d] got=%0b want=%0b", i, bus.flush, i < 2); end
    end
    total++; if ({bus.flag_z, bus.flag_n} !== 2'b10) begin bad++; $display("FAIL sq_flags got=%b want=10", {bus.flag_z, bus.flag_n}); end
    alu_wr(6'd11, 32'h66, 1'b0, 1'b0);
    step();
    total++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 6'd11, 32'h66}) begin bad++; $display("FAIL post_sq_write got=%b/%0d/%h want=1/11/66", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    idle();
  endtask

  task automatic test_bubbles();
    logic [4:0] pat;
    logic [4:0] exp_fl;
    pat    = 5'b11001;  // LSB first: 1,0,0,1,1
    exp_fl = 5'b01111;  // flush after each slot: 1,1,1,1,0
    drive(1'b1, 2'b11, 1'b0, 6'd0, 4'b0100, 32'h0, 32'h0, 32'h0, 32'h300, 1'b0, 1'b0);
    step();
    total++; if ({bus.redirect, bus.redirect_pc} !== {1'b1, 32'h300}) begin bad++; $display("FAIL jmp_redirect got=%b/%h want=1/300", bus.redirect, bus.redirect_pc); end
    for (int i = 0; i < 5; i++) begin
      drive(pat[i], 2'b00, 1'b1, 6'd12, 4'b0000, 32'h77, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      total++; if (bus.flush !== exp_fl[i]) begin bad++; $display("FAIL bub_flush[%0d] got=%0b want=%0b", i, bus.flush, exp_fl[i]); end
      total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL bub_we[%0d] got=%0b want=0", i, bus.rf_we); end
    end
    idle();
    step();
    total++; if ({bus.redirect, bus.redirect_pc} !== {1'b0, 32'h300}) begin bad++; $display("FAIL bub_hold got=%b/%h want=0/300", bus.redirect, bus.redirect_pc); end
  endtask

  task automatic test_priority();
    drive(1'b1, 2'b11, 1'b0, 6'd0, 4'b1100, 32'h0, 32'h100, 32'h0, 32'h200, 1'b0, 1'b0);
    step();
    total++; if ({bus.redirect, bus.redirect_pc} !== {1'b1, 32'h100}) begin bad++; $display("FAIL prio_rpc got=%b/%h want=1/100", bus.redirect, bus.redirect_pc); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, 1'b0, 6'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
    end
    total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL prio_flush_end got=%0b want=0", bus.flush); end
    // Flags are z=0 n=0 here, so brn is not taken
    drive(1'b1, 2'b11, 1'b0, 6'd0, 4'b0001, 32'h0, 32'h0, 32'h0, 32'h500, 1'b0, 1'b0);
    step();
    total++; if ({bus.redirect, bus.flush, bus.redirect_pc} !== {1'b0, 1'b0, 32'h100}) begin bad++; $display("FAIL brn_nt got=%b/%b/%h want=0/0/100", bus.redirect, bus.flush, bus.redirect_pc); end
    idle();
    step();
  endtask

  task automatic test_reset_mid_squash();
    drive(1'b1, 2'b11, 1'b0, 6'd0, 4'b0100, 32'h0, 32'h0, 32'h0, 32'h700, 1'b0, 1'b0);
    step();
    alu_wr(6'd13, 32'h1, 1'b1, 1'b1);
    step();
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL mid_flush got=%0b want=1", bus.flush); end
    idle();
    reset = 1'b1;
    #1;
    total++; if ({bus.rf_we, bus.redirect, bus.flush, bus.flag_z, bus.flag_n} !== 5'b0) begin bad++; $display("FAIL mid_rst_bits got=%b want=00000", {bus.rf_we, bus.redirect, bus.flush, bus.flag_z, bus.flag_n}); end
    total++; if ({bus.rf_waddr, bus.rf_wdata, bus.redirect_pc} !== 70'h0) begin bad++; $display("FAIL mid_rst_regs got=%0d/%h/%h want=0/0/0", bus.rf_waddr, bus.rf_wdata, bus.redirect_pc); end
`ifdef WB_PERF_CNT_EN
    total++; if ({retired_cnt, squashed_cnt} !== 64'h0) begin bad++; $display("FAIL mid_rst_cnt got=%0d/%0d want=0/0", retired_cnt, squashed_cnt); end
`endif
    reset = 1'b0;
    alu_wr(6'd6, 32'h77, 1'b0, 1'b0);
    step();
    total++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.flush} !== {1'b1, 6'd6, 32'h77, 1'b0}) begin bad++; $display("FAIL post_rst_write got=%b/%0d/%h/%b want=1/6/77/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.flush); end
`ifdef WB_PERF_CNT_EN
    total++; if ({retired_cnt, squashed_cnt} !== {32'd1, 32'd0}) begin bad++; $display("FAIL post_rst_cnt got=%0d/%0d want=1/0", retired_cnt, squashed_cnt); end
`endif
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_sources();
    test_back_to_back();
    test_branch_squash();
    test_bubbles();
    test_priority();
    test_reset_mid_squash();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
